// File: rtl/antic_line_buffer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | antic_line_buffer: captures one mode line of playfield DMA bytes, then      |
// | replays them on repeat scanlines.                              Rev 1.0      |
// +-----------------------------------------------------------------------------+
module antic_line_buffer #(
  parameter int DEPTH = 48,
  parameter int WIDTH = 8
) (
  input  logic             phi2,
  input  logic             rst_L,
  input  logic             newLine,
  input  logic             lineStart,
  input  logic [6:0]       numBytes,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] DB,
  input  logic             rd_en,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             lineDone,
  output logic [1:0]       curr_state,
  output logic [5:0]       length,
  output logic             ovf
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_FILL   = 2'b01,
    S_HOLD   = 2'b10,
    S_REPLAY = 2'b11
  } state_t;

  localparam logic [6:0] c_depth_w7 = 7'(DEPTH);
  localparam logic [5:0] c_depth_w6 = 6'(DEPTH);

  state_t           r_state, w_state_nxt;
  logic [5:0]       r_wr_ptr, w_wr_ptr_nxt;
  logic [5:0]       r_rd_ptr, w_rd_ptr_nxt;
  logic [5:0]       r_length, w_length_nxt;
  logic [WIDTH-1:0] r_data_out, w_data_out_nxt;
  logic             r_data_valid, w_data_valid_nxt;
  logic             r_line_done, w_line_done_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic             w_mem_we;
  logic [5:0]       w_wr_ptr_inc;
  logic [5:0]       w_rd_ptr_inc;
  logic [WIDTH-1:0] r_mem [DEPTH];

  assign w_wr_ptr_inc = r_wr_ptr + 6'd1;
  assign w_rd_ptr_inc = r_rd_ptr + 6'd1;

  always_comb begin
    w_state_nxt      = r_state;
    w_wr_ptr_nxt     = r_wr_ptr;
    w_rd_ptr_nxt     = r_rd_ptr;
    w_length_nxt     = r_length;
    w_data_out_nxt   = r_data_out;
    w_data_valid_nxt = 1'b0;
    w_line_done_nxt  = 1'b0;
    w_ovf_nxt        = r_ovf;
    w_mem_we         = 1'b0;

    if (newLine) begin
      w_length_nxt = (numBytes > c_depth_w7) ? c_depth_w6 : numBytes[5:0];
      w_ovf_nxt    = (numBytes > c_depth_w7);
      w_wr_ptr_nxt = 6'd0;
      w_rd_ptr_nxt = 6'd0;
      if (numBytes == 7'd0) begin
        w_state_nxt     = S_HOLD;
        w_line_done_nxt = 1'b1;
      end else begin
        w_state_nxt = S_FILL;
      end
    end else begin
      // DMA bytes are only expected while filling; anything else is lost
      if (wr_en && (r_state != S_FILL)) w_ovf_nxt = 1'b1;

      case (r_state)
        S_FILL: begin
          if (wr_en) begin
            w_mem_we         = 1'b1;
            w_data_out_nxt   = DB;
            w_data_valid_nxt = 1'b1;
            w_wr_ptr_nxt     = w_wr_ptr_inc;
            if (w_wr_ptr_inc == r_length) begin
              w_state_nxt     = S_HOLD;
              w_line_done_nxt = 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (lineStart) begin
            if (r_length == 6'd0) begin
              w_line_done_nxt = 1'b1;
            end else begin
              w_state_nxt  = S_REPLAY;
              w_rd_ptr_nxt = 6'd0;
            end
          end
        end
        S_REPLAY: begin
          if (lineStart) begin
            w_rd_ptr_nxt = 6'd0;
          end else if (rd_en) begin
            w_data_out_nxt   = r_mem[r_rd_ptr];
            w_data_valid_nxt = 1'b1;
            w_rd_ptr_nxt     = w_rd_ptr_inc;
            if (w_rd_ptr_inc == r_length) begin
              w_state_nxt     = S_HOLD;
              w_line_done_nxt = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge phi2 or negedge rst_L) begin
    if (!rst_L) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= 6'd0;
      r_rd_ptr     <= 6'd0;
      r_length     <= 6'd0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_line_done  <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_wr_ptr     <= w_wr_ptr_nxt;
      r_rd_ptr     <= w_rd_ptr_nxt;
      r_length     <= w_length_nxt;
      r_data_out   <= w_data_out_nxt;
      r_data_valid <= w_data_valid_nxt;
      r_line_done  <= w_line_done_nxt;
      r_ovf        <= w_ovf_nxt;
    end
  end

  // Storage is deliberately outside the reset domain so contents survive rst_L
  always_ff @(posedge phi2) begin
    if (w_mem_we) r_mem[r_wr_ptr] <= DB;
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign lineDone   = r_line_done;
  assign curr_state = r_state;
  assign length     = r_length;
  assign ovf        = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_antic_line_buffer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_antic_line_buffer: directed and random stimulus against a line model.    |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_antic_line_buffer;

  localparam int M_IDLE = 0, M_FILL = 1, M_HOLD = 2, M_REPLAY = 3;

  logic       phi2, rst_L, newLine, lineStart, wr_en, rd_en;
  logic [6:0] numBytes;
  logic [7:0] DB, data_out;
  logic       data_valid, lineDone, ovf;
  logic [1:0] curr_state;
  logic [5:0] length;

  int checks = 0;
  int errors = 0;

  // Reference: the line is an array of bytes plus counts of bytes written/read
  int         m_mode, m_len, m_wcnt, m_rcnt;
  bit         m_ovf, m_valid, m_done;
  logic [7:0] m_dout;
  logic [7:0] m_line [48];

  antic_line_buffer #(.DEPTH(48), .WIDTH(8)) dut (
    .phi2(phi2), .rst_L(rst_L), .newLine(newLine), .lineStart(lineStart),
    .numBytes(numBytes), .wr_en(wr_en), .DB(DB), .rd_en(rd_en),
    .data_out(data_out), .data_valid(data_valid), .lineDone(lineDone),
    .curr_state(curr_state), .length(length), .ovf(ovf)
  );

  initial phi2 = 1'b0;
  always #5 phi2 = ~phi2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".state"},      32'(curr_state), 32'(m_mode));
    check({tag, ".length"},     32'(length),     32'(m_len));
    check({tag, ".ovf"},        32'(ovf),        32'(m_ovf));
    check({tag, ".data_valid"}, 32'(data_valid), 32'(m_valid));
    check({tag, ".lineDone"},   32'(lineDone),   32'(m_done));
    check({tag, ".data_out"},   32'(data_out),   32'(m_dout));
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_len = 0; m_wcnt = 0; m_rcnt = 0;
    m_ovf = 0; m_valid = 0; m_done = 0; m_dout = 8'h00;
  endtask

  task automatic model_update(input bit nl, input bit ls, input bit we, input bit re,
                              input logic [7:0] db, input int nb);
    int prev;
    prev    = m_mode;
    m_valid = 0;
    m_done  = 0;
    if (nl) begin
      m_len  = (nb > 48) ? 48 : nb;
      m_ovf  = (nb > 48);
      m_wcnt = 0;
      m_rcnt = 0;
      if (m_len == 0) begin m_mode = M_HOLD; m_done = 1; end
      else m_mode = M_FILL;
    end else begin
      if (we && prev != M_FILL) m_ovf = 1;
      if (prev == M_FILL && we) begin
        m_line[m_wcnt] = db;
        m_dout  = db;
        m_valid = 1;
        m_wcnt++;
        if (m_wcnt == m_len) begin m_mode = M_HOLD; m_done = 1; end
      end else if ((prev == M_HOLD || prev == M_REPLAY) && ls) begin
        if (m_len == 0) m_done = 1;
        else begin m_mode = M_REPLAY; m_rcnt = 0; end
      end else if (prev == M_REPLAY && re) begin
        m_dout  = m_line[m_rcnt];
        m_valid = 1;
        m_rcnt++;
        if (m_rcnt == m_len) begin m_mode = M_HOLD; m_done = 1; end
      end
    end
  endtask

  // One clock: drive, clock, predict, sample 1 ns after the edge
  task automatic cycle(input bit nl, input bit ls, input bit we, input bit re,
                       input logic [7:0] db, input int nb, input string tag);
    newLine = nl; lineStart = ls; wr_en = we; rd_en = re; DB = db; numBytes = 7'(nb);
    @(posedge phi2);
    model_update(nl, ls, we, re, db, nb);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst_L = 1'b0; newLine = 0; lineStart = 0; wr_en = 0; rd_en = 0; DB = 0; numBytes = 0;
    model_reset();
    repeat (2) @(posedge phi2);
    #1;
    check_all("reset");
    rst_L = 1'b1;

    // 1: 40-byte fill with pass-through
    cycle(1, 0, 0, 0, 8'h00, 40, "s1.newline");
    for (int i = 0; i < 40; i++) cycle(0, 0, 1, 0, 8'(i), 0, "s1.fill");
    cycle(0, 0, 0, 0, 8'h00, 0, "s1.idle");

    // 2: back-to-back replay, then every other cycle
    cycle(0, 1, 0, 0, 8'h00, 0, "s2.start");
    for (int i = 0; i < 40; i++) cycle(0, 0, 0, 1, 8'h00, 0, "s2.b2b");
    cycle(0, 1, 0, 0, 8'h00, 0, "s2.start2");
    for (int i = 0; i < 82; i++) cycle(0, 0, 0, (i % 2 == 0), 8'h00, 0, "s2.spaced");

    // 3: oversized line clamps and flags, overflow write in HOLD
    cycle(1, 0, 0, 0, 8'h00, 60, "s3.newline");
    for (int i = 0; i < 48; i++) cycle(0, 0, 1, 0, 8'($urandom), 0, "s3.fill");
    cycle(0, 0, 1, 0, 8'hEE, 0, "s3.extra");
    cycle(0, 0, 0, 0, 8'h00, 0, "s3.idle");
    cycle(1, 0, 1, 0, 8'h55, 8, "s3.newline8");

    // 4: zero-length line
    cycle(1, 0, 0, 0, 8'h00, 0, "s4.newline0");
    cycle(0, 0, 0, 0, 8'h00, 0, "s4.after");
    cycle(0, 1, 0, 0, 8'h00, 0, "s4.start");
    cycle(0, 0, 0, 1, 8'h00, 0, "s4.after2");

    // 5: restart mid-replay, then abandon replay with newLine
    cycle(1, 0, 0, 0, 8'h00, 20, "s5.newline");
    for (int i = 0; i < 20; i++) cycle(0, 0, 1, 0, 8'(8'hA0 + i), 0, "s5.fill");
    cycle(0, 1, 0, 0, 8'h00, 0, "s5.start");
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 1, 8'h00, 0, "s5.read");
    cycle(0, 1, 0, 1, 8'h00, 0, "s5.restart");
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 8'h00, 0, "s5.reread");
    cycle(1, 0, 0, 1, 8'h00, 16, "s5.midnew");
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 8'h00, 0, "s5.noreplay");

    // 6: asynchronous reset in the middle of the fill
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, 8'(8'h30 + i), 0, "s6.fill");
    wr_en = 1'b1; DB = 8'h77;
    #2;
    rst_L = 1'b0;
    #1;
    model_reset();
    check_all("s6.async");
    wr_en = 1'b0;
    @(posedge phi2);
    #1;
    check_all("s6.held");
    rst_L = 1'b1;
    cycle(0, 1, 0, 0, 8'h00, 0, "s6.start");
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 8'h00, 0, "s6.read");
    cycle(0, 0, 1, 0, 8'h12, 0, "s6.idlewr");

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bit nl, ls, we, re;
      int nb;
      nl = ($urandom_range(0, 99) < 2);
      nb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 12);
      ls = !nl && ($urandom_range(0, 24) == 0);
      we = !ls && ($urandom_range(0, 2) != 0);
      re = ($urandom_range(0, 1) == 1);
      cycle(nl, ls, we, re, 8'($urandom), nb, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
